// File: rtl/as_lut_lookup_requester.sv
// Anti-spoof lookup initiator: parses header fields from the packet tap, runs one
// four-phase MAC/IP lookup per packet and holds the returned port mask as a token.
module as_lut_lookup_requester #(
  parameter int                    DATA_WIDTH        = 64,
  parameter int                    CTRL_WIDTH        = 8,
  parameter int                    NUM_OUTPUT_QUEUES = 8,
  parameter int                    NUM_IQ_BITS       = 3,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM     = 8'hFF,
  parameter int                    IOQ_SRC_PORT_POS  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [47:0]                  dst_mac,
  output logic [47:0]                  src_mac,
  output logic [31:0]                  dst_ip,
  output logic [31:0]                  src_ip,
  output logic [NUM_IQ_BITS-1:0]       src_port,
  output logic                         lookup_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
  input  logic                         lookup_ack,
  output logic [NUM_OUTPUT_QUEUES-1:0] result_ports,
  output logic [NUM_IQ_BITS-1:0]       result_src_port,
  output logic                         result_vld,
  input  logic                         result_rd,
  output logic                         lookup_done
);

  typedef enum logic [1:0] {P_HDR, P_DATA, P_EOP} pstate_t;
  typedef enum logic [1:0] {L_IDLE, L_REQ, L_REL} lstate_t;

  pstate_t pstate_q, pstate_d;
  lstate_t lstate_q, lstate_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [47:0] p_dst_mac_q, p_dst_mac_d, p_src_mac_q, p_src_mac_d;
  logic [31:0] p_dst_ip_q, p_dst_ip_d, p_src_ip_q, p_src_ip_d;
  logic [NUM_IQ_BITS-1:0] p_src_port_q, p_src_port_d;
  logic pending_q, pending_d;
  logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
  logic [31:0] dst_ip_q, dst_ip_d, src_ip_q, src_ip_d;
  logic [NUM_IQ_BITS-1:0] src_port_q, src_port_d;
  logic lookup_req_q, lookup_req_d;
  logic [NUM_OUTPUT_QUEUES-1:0] result_ports_q, result_ports_d;
  logic [NUM_IQ_BITS-1:0] result_src_port_q, result_src_port_d;
  logic result_vld_q, result_vld_d;
  logic lookup_done_q, lookup_done_d;

  logic       acc, launch, complete;
  logic [2:0] idx;

  always_comb begin
    pstate_d     = pstate_q;
    wcnt_d       = wcnt_q;
    p_dst_mac_d  = p_dst_mac_q;
    p_src_mac_d  = p_src_mac_q;
    p_dst_ip_d   = p_dst_ip_q;
    p_src_ip_d   = p_src_ip_q;
    p_src_port_d = p_src_port_q;
    complete     = 1'b0;
    idx          = wcnt_q + 3'd1;
    acc          = in_wr && !pending_q;
    launch       = (lstate_q == L_IDLE) && pending_q;

    // Parser registers are free once the launch has copied them out.
    if (launch) begin
      p_dst_mac_d  = '0;
      p_src_mac_d  = '0;
      p_dst_ip_d   = '0;
      p_src_ip_d   = '0;
      p_src_port_d = '0;
    end

    case (pstate_q)
      P_HDR: if (acc) begin
        if (in_ctrl != '0) begin
          if (in_ctrl == IOQ_STAGE_NUM)
            p_src_port_d = in_data[IOQ_SRC_PORT_POS +: NUM_IQ_BITS];
        end else begin
          p_dst_mac_d        = in_data[63:16];
          p_src_mac_d[47:32] = in_data[15:0];
          wcnt_d             = 3'd1;
          pstate_d           = P_DATA;
        end
      end
      P_DATA: if (acc) begin
        wcnt_d = idx;
        case (idx)
          3'd2: p_src_mac_d[31:0] = in_data[63:32];
          3'd4: begin
            p_src_ip_d         = in_data[47:16];
            p_dst_ip_d[31:16]  = in_data[15:0];
          end
          3'd5: p_dst_ip_d[15:0] = in_data[63:48];
          default: ;
        endcase
        if (idx == 3'd5 || in_ctrl != '0) begin
          complete = 1'b1;
          pstate_d = (in_ctrl != '0) ? P_HDR : P_EOP;
        end
      end
      P_EOP: if (acc && in_ctrl != '0) pstate_d = P_HDR;
      default: pstate_d = P_HDR;
    endcase

    pending_d = pending_q;
    if (launch)   pending_d = 1'b0;
    if (complete) pending_d = 1'b1;
  end

  always_comb begin
    lstate_d          = lstate_q;
    dst_mac_d         = dst_mac_q;
    src_mac_d         = src_mac_q;
    dst_ip_d          = dst_ip_q;
    src_ip_d          = src_ip_q;
    src_port_d        = src_port_q;
    lookup_req_d      = lookup_req_q;
    result_ports_d    = result_ports_q;
    result_src_port_d = result_src_port_q;
    result_vld_d      = result_vld_q;
    lookup_done_d     = 1'b0;

    if (result_vld_q && result_rd) result_vld_d = 1'b0;

    case (lstate_q)
      L_IDLE: if (pending_q) begin
        dst_mac_d    = p_dst_mac_q;
        src_mac_d    = p_src_mac_q;
        dst_ip_d     = p_dst_ip_q;
        src_ip_d     = p_src_ip_q;
        src_port_d   = p_src_port_q;
        lookup_req_d = 1'b1;
        lstate_d     = L_REQ;
      end
      L_REQ: if (lookup_ack) begin
        result_ports_d    = dst_ports;
        result_src_port_d = src_port_q;
        result_vld_d      = 1'b1;
        lookup_done_d     = 1'b1;
        lookup_req_d      = 1'b0;
        lstate_d          = L_REL;
      end
      // Four-phase release: the responder must drop ack and the token must be gone.
      L_REL: if (!lookup_ack && !result_vld_q) lstate_d = L_IDLE;
      default: lstate_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate_q          <= P_HDR;
      lstate_q          <= L_IDLE;
      wcnt_q            <= '0;
      p_dst_mac_q       <= '0;
      p_src_mac_q       <= '0;
      p_dst_ip_q        <= '0;
      p_src_ip_q        <= '0;
      p_src_port_q      <= '0;
      pending_q         <= 1'b0;
      dst_mac_q         <= '0;
      src_mac_q         <= '0;
      dst_ip_q          <= '0;
      src_ip_q          <= '0;
      src_port_q        <= '0;
      lookup_req_q      <= 1'b0;
      result_ports_q    <= '0;
      result_src_port_q <= '0;
      result_vld_q      <= 1'b0;
      lookup_done_q     <= 1'b0;
    end else begin
      pstate_q          <= pstate_d;
      lstate_q          <= lstate_d;
      wcnt_q            <= wcnt_d;
      p_dst_mac_q       <= p_dst_mac_d;
      p_src_mac_q       <= p_src_mac_d;
      p_dst_ip_q        <= p_dst_ip_d;
      p_src_ip_q        <= p_src_ip_d;
      p_src_port_q      <= p_src_port_d;
      pending_q         <= pending_d;
      dst_mac_q         <= dst_mac_d;
      src_mac_q         <= src_mac_d;
      dst_ip_q          <= dst_ip_d;
      src_ip_q          <= src_ip_d;
      src_port_q        <= src_port_d;
      lookup_req_q      <= lookup_req_d;
      result_ports_q    <= result_ports_d;
      result_src_port_q <= result_src_port_d;
      result_vld_q      <= result_vld_d;
      lookup_done_q     <= lookup_done_d;
    end
  end

  assign in_rdy          = !pending_q;
  assign dst_mac         = dst_mac_q;
  assign src_mac         = src_mac_q;
  assign dst_ip          = dst_ip_q;
  assign src_ip          = src_ip_q;
  assign src_port        = src_port_q;
  assign lookup_req      = lookup_req_q;
  assign result_ports    = result_ports_q;
  assign result_src_port = result_src_port_q;
  assign result_vld      = result_vld_q;
  assign lookup_done     = lookup_done_q;

endmodule

// File: tb/tb_as_lut_lookup_requester.sv
// Bench for as_lut_lookup_requester: directed packets, queued expectations checked
// by a monitor on each lookup request and each consumed result token.
module tb_as_lut_lookup_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [47:0] dst_mac, src_mac;
  logic [31:0] dst_ip, src_ip;
  logic [2:0]  src_port;
  logic        lookup_req;
  logic [7:0]  dst_ports;
  logic        lookup_ack;
  logic [7:0]  result_ports;
  logic [2:0]  result_src_port;
  logic        result_vld;
  logic        result_rd;
  logic        lookup_done;

  as_lut_lookup_requester dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .dst_mac(dst_mac), .src_mac(src_mac), .dst_ip(dst_ip), .src_ip(src_ip),
    .src_port(src_port), .lookup_req(lookup_req), .dst_ports(dst_ports),
    .lookup_ack(lookup_ack), .result_ports(result_ports),
    .result_src_port(result_src_port), .result_vld(result_vld),
    .result_rd(result_rd), .lookup_done(lookup_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [2:0]  port;
  } req_t;
  typedef struct {
    logic [7:0] ports;
    logic [2:0] port;
  } res_t;

  req_t       req_q[$];
  res_t       res_q[$];
  logic [7:0] ans_q[$];

  int tests = 0, fails = 0;
  int done_cnt = 0, exp_done = 0;
  int ack_delay = 3, ack_hold = 1;
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_vld = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0; prev_ack = 1'b0; prev_vld = 1'b0;
    end else begin
      if (lookup_req && !prev_req) begin
        req_t e;
        chk("req_after_ack_low", {63'd0, prev_ack}, 64'd0);
        if (req_q.size() == 0) chk("unexpected_req", 64'd1, 64'd0);
        else begin
          e = req_q.pop_front();
          chk("dst_mac", {16'd0, dst_mac}, {16'd0, e.dmac});
          chk("src_mac", {16'd0, src_mac}, {16'd0, e.smac});
          chk("src_ip", {32'd0, src_ip}, {32'd0, e.sip});
          chk("dst_ip", {32'd0, dst_ip}, {32'd0, e.dip});
          chk("src_port", {61'd0, src_port}, {61'd0, e.port});
        end
      end
      if (lookup_done) done_cnt++;
      if (lookup_done || (result_vld && !prev_vld))
        chk("done_with_vld_rise", {63'd0, lookup_done}, {63'd0, result_vld && !prev_vld});
      if (result_vld && result_rd) begin
        res_t r;
        if (res_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
        else begin
          r = res_q.pop_front();
          chk("result_ports", {56'd0, result_ports}, {56'd0, r.ports});
          chk("result_src_port", {61'd0, result_src_port}, {61'd0, r.port});
        end
      end
      prev_req = lookup_req; prev_ack = lookup_ack; prev_vld = result_vld;
    end
  end

  // LUT responder: ack after ack_delay cycles, scramble dst_ports after the first ack cycle
  bit resp_abort;
  initial begin
    lookup_ack = 1'b0;
    dst_ports  = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset && lookup_req) begin
        resp_abort = 1'b0;
        for (int i = 0; i < ack_delay; i++) begin
          @(posedge clk);
          if (reset) begin resp_abort = 1'b1; break; end
        end
        if (!resp_abort) begin
          #1;
          lookup_ack = 1'b1;
          dst_ports  = (ans_q.size() != 0) ? ans_q.pop_front() : 8'h00;
          @(posedge clk); #1;
          dst_ports = ~dst_ports;
          repeat (ack_hold) @(posedge clk);
          #1 lookup_ack = 1'b0;
        end
        while (reset) @(posedge clk);
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int n = 0;
    @(posedge clk); #1;
    while (!in_rdy && n < 300) begin
      in_wr = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (!in_rdy) chk("in_rdy_timeout", 64'd0, 64'd1);
    in_wr = 1'b1; in_data = d; in_ctrl = c;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_wr = 1'b0; in_ctrl = 8'h00;
  endtask

  // eop = index of the EOP word; 6 means w1..w5 are sent and the caller sends the tail
  task automatic send_pkt(input logic [2:0] port, input logic [47:0] dmac, input logic [47:0] smac,
                          input logic [31:0] sip, input logic [31:0] dip, input int eop,
                          input logic [7:0] ans, input bit exp_res);
    req_t r;
    res_t s;
    logic [63:0] w [1:5];
    r.dmac = dmac;
    r.smac = smac;
    r.sip  = (eop >= 4) ? sip : 32'h0;
    r.dip  = {(eop >= 4) ? dip[31:16] : 16'h0, (eop >= 5) ? dip[15:0] : 16'h0};
    r.port = port;
    req_q.push_back(r);
    if (exp_res) begin
      s.ports = ans; s.port = port;
      ans_q.push_back(ans);
      res_q.push_back(s);
      exp_done++;
    end
    w[1] = {dmac, smac[47:32]};
    w[2] = {smac[31:0], 16'h0800, 16'h4500};
    w[3] = 64'h0054_1234_4000_4006;
    w[4] = {16'hBEEF, sip, dip[31:16]};
    w[5] = {dip[15:0], 48'h0102_0304_0506};
    send_word(64'h0000_0008_0000_0040 | ({61'd0, port} << 16), 8'hFF);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'h10);
    for (int i = 1; i <= 5 && i <= eop; i++)
      send_word(w[i], (i == eop) ? 8'h01 : 8'h00);
    idle();
  endtask

  task automatic send_tail();
    send_word(64'hDEAD_BEEF_0000_1111, 8'h01);
    idle();
  endtask

  task automatic drain();
    int n = 0;
    while ((req_q.size() != 0 || res_q.size() != 0 || lookup_req) && n < 500) begin
      @(negedge clk); n++;
    end
    if (n >= 500) chk("drain_timeout", 64'd1, 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_rdy, bad_req, n;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; result_rd = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("rst_lookup_req", {63'd0, lookup_req}, 64'd0);
    chk("rst_result_vld", {63'd0, result_vld}, 64'd0);
    chk("rst_lookup_done", {63'd0, lookup_done}, 64'd0);
    chk("rst_result_ports", {56'd0, result_ports}, 64'd0);
    chk("rst_dst_mac", {16'd0, dst_mac}, 64'd0);

    // Single packet with launch timing
    send_pkt(3'd2, 48'h0011_2233_4455, 48'h6677_8899_AABB, 32'h0A00_0001, 32'h0A00_0002, 6, 8'h10, 1);
    @(negedge clk);
    chk("t1_in_rdy", {63'd0, in_rdy}, 64'd0);
    chk("t1_lookup_req", {63'd0, lookup_req}, 64'd0);
    @(negedge clk);
    chk("t2_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("t2_lookup_req", {63'd0, lookup_req}, 64'd1);
    send_tail();
    drain();

    // Four-phase: long ack hold with a second packet waiting
    ack_hold = 5;
    send_pkt(3'd5, 48'h0A0B_0C0D_0E0F, 48'h1020_3040_5060, 32'hC0A8_0101, 32'hC0A8_0102, 6, 8'h21, 1);
    send_tail();
    send_pkt(3'd1, 48'hFFEE_DDCC_BBAA, 48'h0102_0304_0506, 32'hAC10_0001, 32'hAC10_FFFE, 6, 8'h42, 1);
    send_tail();
    drain();
    ack_hold = 1;

    // Back-pressure: results not consumed
    @(posedge clk); #1 result_rd = 1'b0;
    send_pkt(3'd3, 48'h0200_0000_00A1, 48'h0200_0000_00A2, 32'h0101_0101, 32'h0202_0202, 6, 8'h81, 1);
    send_tail();
    send_pkt(3'd6, 48'h0200_0000_00B1, 48'h0200_0000_00B2, 32'h0303_0303, 32'h0404_0404, 6, 8'h03, 1);
    bad_rdy = 0; bad_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_rdy) bad_rdy++;
      if (lookup_req) bad_req++;
    end
    chk("bp_in_rdy_low", 64'(bad_rdy), 64'd0);
    chk("bp_no_launch", 64'(bad_req), 64'd0);
    chk("bp_result_held", {63'd0, result_vld}, 64'd1);
    @(posedge clk); #1 result_rd = 1'b1;
    @(negedge clk);
    chk("bp_rdy_at_consume", {63'd0, in_rdy}, 64'd0);
    send_tail();
    drain();

    // Short packet (EOP on w3), then a normal packet to prove the parser is back in P_HDR
    send_pkt(3'd4, 48'h0200_0000_0001, 48'h0200_0000_0002, 32'h0102_0304, 32'h0506_0708, 3, 8'h55, 1);
    send_pkt(3'd7, 48'h00AA_BBCC_DDEE, 48'h0011_0022_0033, 32'hC633_6401, 32'hC633_64FE, 6, 8'hA0, 1);
    send_tail();
    drain();

    // Reset asserted while in L_REQ
    ack_delay = 10;
    send_pkt(3'd1, 48'h1111_2222_3333, 48'h4444_5555_6666, 32'h7777_8888, 32'h9999_AAAA, 6, 8'h00, 0);
    send_tail();
    n = 0;
    while (!lookup_req && n < 50) begin @(negedge clk); n++; end
    chk("rst_test_req_seen", {63'd0, lookup_req}, 64'd1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_rst_lookup_req", {63'd0, lookup_req}, 64'd0);
    chk("async_rst_result_vld", {63'd0, result_vld}, 64'd0);
    chk("async_rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("async_rst_result_ports", {56'd0, result_ports}, 64'd0);
    chk("async_rst_dst_mac", {16'd0, dst_mac}, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    ack_delay = 2;
    send_pkt(3'd3, 48'hABCD_EF01_2345, 48'h5432_10FE_DCBA, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 6, 8'h0F, 1);
    send_tail();
    drain();

    chk("lookup_done_count", 64'(done_cnt), 64'(exp_done));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
